window_sched: RTL and testbench

Sequences the sliding-window datapath into the downstream classifier engine. Consumes the one-cycle `win_valid` strobe from the window generator. Forwards every `cfg_stride`-th full window by pulsing a same-cycle capture strobe and a registered engine start. Tracks engine occupancy and counts windows that were due while the engine was occupied.

---
 rtl/window_sched_if.sv | 28 ++
 rtl/window_sched.sv | 123 ++++++++++++
 tb/tb_window_sched.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_sched_if.sv
// Bundles the run-control, window strobe, engine handshake and statistics of window_sched.
// master drives the requests and strobes; slave is the scheduler itself.
interface window_sched_if #(
  parameter int STRIDE_W = 8,
  parameter int CNT_W    = 16
);
  logic                enable;
  logic [STRIDE_W-1:0] cfg_stride;
  logic                win_valid;
  logic                eng_done;
  logic                clr_stats;
  logic                capture;
  logic                eng_start;
  logic                busy;
  logic [CNT_W-1:0]    issued_cnt;
  logic [CNT_W-1:0]    drop_cnt;
  logic                overrun;

  modport master (
    output enable, cfg_stride, win_valid, eng_done, clr_stats,
    input  capture, eng_start, busy, issued_cnt, drop_cnt, overrun
  );

  modport slave (
    input  enable, cfg_stride, win_valid, eng_done, clr_stats,
    output capture, eng_start, busy, issued_cnt, drop_cnt, overrun
  );
endinterface

// File: rtl/window_sched.sv
// Forwards every stride-th window from the window generator to the classifier engine,
// tracking engine occupancy and counting due windows that arrive while it is occupied.
module window_sched #(
  parameter int STRIDE_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  window_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, LAUNCH, BUSY} state_t;

  state_t              state;
  logic [STRIDE_W-1:0] stride_q;
  logic [STRIDE_W-1:0] phase;
  logic                start_q;
  logic                busy_q;
  logic [CNT_W-1:0]    issued_q;
  logic [CNT_W-1:0]    drop_q;
  logic                overrun_q;
  logic                due;
  logic                take;
  logic                drop;

  // A due window is either taken (engine free, run requested) or dropped (engine occupied).
  always_comb begin
    due  = bus.win_valid && (phase == '0) && (state != IDLE);
    take = 1'b0;
    drop = 1'b0;
    case (state)
      ARMED:   take = due && bus.enable;
      LAUNCH:  drop = due;
      BUSY: begin
        if (bus.eng_done) take = due && bus.enable;
        else              drop = due;
      end
      default: ;
    endcase
  end

  assign bus.capture    = take;
  assign bus.eng_start  = start_q;
  assign bus.busy       = busy_q;
  assign bus.issued_cnt = issued_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stride_q  <= STRIDE_W'(1);
      phase     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      issued_q  <= '0;
      drop_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      start_q <= take;

      if (state != IDLE && bus.win_valid)
        phase <= (phase == stride_q - 1'b1) ? '0 : phase + 1'b1;

      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.enable) begin
            // Stride 0 behaves as stride 1, so the latched value is never 0.
            stride_q <= (bus.cfg_stride == '0) ? STRIDE_W'(1) : bus.cfg_stride;
            phase    <= '0;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (!bus.enable) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (take) begin
            state  <= LAUNCH;
            busy_q <= 1'b1;
          end
        end
        LAUNCH: begin
          state  <= BUSY;
          busy_q <= 1'b1;
        end
        BUSY: begin
          if (bus.eng_done) begin
            if (take) begin
              state  <= LAUNCH;
              busy_q <= 1'b1;
            end else if (bus.enable) begin
              state  <= ARMED;
              busy_q <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      // Clearing wins over any increment or drop in the same cycle.
      if (bus.clr_stats) begin
        issued_q  <= '0;
        drop_q    <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (take) issued_q <= issued_q + 1'b1;
        if (drop) begin
          overrun_q <= 1'b1;
          if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_sched.sv
// Self-checking bench for window_sched: expected capture cycles go into a scoreboard queue
// as stimulus is driven and are matched against captures and start pulses seen on the bus.
module tb_window_sched;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  int   exp_cap[$];
  int   cap_log[$];
  int   start_log[$];

  window_sched_if #(.STRIDE_W(8), .CNT_W(16)) bus ();

  window_sched #(.STRIDE_W(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every capture and start pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (bus.capture === 1'b1)   cap_log.push_back(cyc);
    if (bus.eng_start === 1'b1) start_log.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.enable     = 1'b0;
    bus.cfg_stride = 8'd0;
    bus.win_valid  = 1'b0;
    bus.eng_done   = 1'b0;
    bus.clr_stats  = 1'b0;
  endtask

  task automatic apply_reset();
    quiet_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    exp_cap.delete();
    cap_log.delete();
    start_log.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run += 5;
    if (bus.eng_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset eng_start: got %b, want 0", bus.eng_start); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy: got %b, want 0", bus.busy); end
    if (bus.issued_cnt !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset issued_cnt: got %h, want 0", bus.issued_cnt); end
    if (bus.drop_cnt !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset drop_cnt: got %h, want 0", bus.drop_cnt); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset overrun: got %b, want 0", bus.overrun); end
    bus.win_valid = 1'b1;
    #1;
    tests_run++;
    if (bus.capture !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle capture: got %b, want 0", bus.capture); end
    next_cycle();
    bus.win_valid = 1'b0;
    next_cycle();
    tests_run++;
    if (bus.eng_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle eng_start: got %b, want 0", bus.eng_start); end
  endtask

  task automatic test_stride4();
    int e, g, s;
    apply_reset();
    bus.enable = 1'b1;
    bus.cfg_stride = 8'd4;
    next_cycle();
    for (int i = 1; i <= 12; i++) begin
      bus.win_valid = 1'b1;
      bus.eng_done  = (i % 4 == 3);
      if (i % 4 == 1) exp_cap.push_back(cyc);
      next_cycle();
    end
    bus.win_valid = 1'b0;
    bus.eng_done  = 1'b0;
    next_cycle();
    next_cycle();
    while (exp_cap.size() > 0) begin
      e = exp_cap.pop_front();
      g = -1; s = -1;
      if (cap_log.size() > 0) g = cap_log.pop_front();
      if (start_log.size() > 0) s = start_log.pop_front();
      tests_run += 2;
      if (g !== e) begin tests_failed++; $display("[TB] FAIL stride4 capture: got cycle %0d, want %0d", g, e); end
      if (s !== e + 1) begin tests_failed++; $display("[TB] FAIL stride4 eng_start: got cycle %0d, want %0d", s, e + 1); end
    end
    tests_run += 4;
    if (cap_log.size() + start_log.size() != 0) begin tests_failed++; $display("[TB] FAIL stride4 extra pulses: got %0d, want 0", cap_log.size() + start_log.size()); end
    if (bus.issued_cnt !== 16'd3) begin tests_failed++; $display("[TB] FAIL stride4 issued_cnt: got %0d, want 3", bus.issued_cnt); end
    if (bus.drop_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL stride4 drop_cnt: got %0d, want 0", bus.drop_cnt); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL stride4 busy: got %b, want 0", bus.busy); end
  endtask

  task automatic test_overrun();
    int e, g, s;
    apply_reset();
    bus.enable = 1'b1;
    bus.cfg_stride = 8'd2;
    next_cycle();
    for (int i = 1; i <= 10; i++) begin
      bus.win_valid = (i <= 8);
      if (i == 1) exp_cap.push_back(cyc);
      next_cycle();
    end
    bus.eng_done = 1'b1;
    next_cycle();
    bus.eng_done = 1'b0;
    while (exp_cap.size() > 0) begin
      e = exp_cap.pop_front();
      g = -1; s = -1;
      if (cap_log.size() > 0) g = cap_log.pop_front();
      if (start_log.size() > 0) s = start_log.pop_front();
      tests_run += 2;
      if (g !== e) begin tests_failed++; $display("[TB] FAIL overrun capture: got cycle %0d, want %0d", g, e); end
      if (s !== e + 1) begin tests_failed++; $display("[TB] FAIL overrun eng_start: got cycle %0d, want %0d", s, e + 1); end
    end
    tests_run += 5;
    if (cap_log.size() + start_log.size() != 0) begin tests_failed++; $display("[TB] FAIL overrun extra pulses: got %0d, want 0", cap_log.size() + start_log.size()); end
    if (bus.issued_cnt !== 16'd1) begin tests_failed++; $display("[TB] FAIL overrun issued_cnt: got %0d, want 1", bus.issued_cnt); end
    if (bus.drop_cnt !== 16'd3) begin tests_failed++; $display("[TB] FAIL overrun drop_cnt: got %0d, want 3", bus.drop_cnt); end
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun flag: got %b, want 1", bus.overrun); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL overrun busy: got %b, want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int e, g, s;
    apply_reset();
    bus.enable = 1'b1;
    bus.cfg_stride = 8'd0;
    next_cycle();
    for (int i = 1; i <= 9; i++) begin
      bus.win_valid = (i <= 8);
      bus.eng_done  = bus.busy;
      if (i % 2 == 1 && i <= 8) exp_cap.push_back(cyc);
      next_cycle();
    end
    bus.win_valid = 1'b0;
    bus.eng_done  = 1'b0;
    while (exp_cap.size() > 0) begin
      e = exp_cap.pop_front();
      g = -1; s = -1;
      if (cap_log.size() > 0) g = cap_log.pop_front();
      if (start_log.size() > 0) s = start_log.pop_front();
      tests_run += 2;
      if (g !== e) begin tests_failed++; $display("[TB] FAIL b2b capture: got cycle %0d, want %0d", g, e); end
      if (s !== e + 1) begin tests_failed++; $display("[TB] FAIL b2b eng_start: got cycle %0d, want %0d", s, e + 1); end
    end
    tests_run += 4;
    if (cap_log.size() + start_log.size() != 0) begin tests_failed++; $display("[TB] FAIL b2b extra pulses: got %0d, want 0", cap_log.size() + start_log.size()); end
    if (bus.issued_cnt !== 16'd4) begin tests_failed++; $display("[TB] FAIL b2b issued_cnt: got %0d, want 4", bus.issued_cnt); end
    if (bus.drop_cnt !== 16'd4) begin tests_failed++; $display("[TB] FAIL b2b drop_cnt: got %0d, want 4", bus.drop_cnt); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b busy: got %b, want 0", bus.busy); end
  endtask

  task automatic test_disable();
    int e, g, s;
    apply_reset();
    bus.enable = 1'b1;
    bus.cfg_stride = 8'd1;
    next_cycle();
    bus.win_valid = 1'b1;
    exp_cap.push_back(cyc);
    next_cycle();
    bus.win_valid = 1'b0;
    next_cycle();
    bus.enable = 1'b0;
    next_cycle();
    bus.win_valid = 1'b1;
    bus.eng_done  = 1'b1;
    next_cycle();
    bus.eng_done = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL disable busy: got %b, want 0", bus.busy); end
    next_cycle();
    bus.win_valid = 1'b0;
    bus.enable    = 1'b1;
    next_cycle();
    bus.win_valid = 1'b1;
    exp_cap.push_back(cyc);
    next_cycle();
    bus.win_valid = 1'b0;
    bus.enable    = 1'b0;
    next_cycle();
    bus.eng_done = 1'b1;
    next_cycle();
    bus.eng_done = 1'b0;
    while (exp_cap.size() > 0) begin
      e = exp_cap.pop_front();
      g = -1; s = -1;
      if (cap_log.size() > 0) g = cap_log.pop_front();
      if (start_log.size() > 0) s = start_log.pop_front();
      tests_run += 2;
      if (g !== e) begin tests_failed++; $display("[TB] FAIL disable capture: got cycle %0d, want %0d", g, e); end
      if (s !== e + 1) begin tests_failed++; $display("[TB] FAIL disable eng_start: got cycle %0d, want %0d", s, e + 1); end
    end
    tests_run += 4;
    if (cap_log.size() + start_log.size() != 0) begin tests_failed++; $display("[TB] FAIL disable extra pulses: got %0d, want 0", cap_log.size() + start_log.size()); end
    if (bus.issued_cnt !== 16'd2) begin tests_failed++; $display("[TB] FAIL disable issued_cnt: got %0d, want 2", bus.issued_cnt); end
    if (bus.drop_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL disable drop_cnt: got %0d, want 0", bus.drop_cnt); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL disable final busy: got %b, want 0", bus.busy); end
  endtask

  task automatic test_saturation();
    int e, g, s;
    apply_reset();
    bus.enable = 1'b1;
    bus.cfg_stride = 8'd1;
    next_cycle();
    exp_cap.push_back(cyc);
    for (int i = 1; i <= 65538; i++) begin
      if (i == 65536) begin
        tests_run++;
        if (bus.drop_cnt !== 16'hFFFE) begin tests_failed++; $display("[TB] FAIL sat near-full drop_cnt: got %h, want fffe", bus.drop_cnt); end
      end
      bus.win_valid = 1'b1;
      next_cycle();
    end
    tests_run += 3;
    if (bus.drop_cnt !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL sat drop_cnt: got %h, want ffff", bus.drop_cnt); end
    if (bus.overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat overrun: got %b, want 1", bus.overrun); end
    if (bus.issued_cnt !== 16'd1) begin tests_failed++; $display("[TB] FAIL sat issued_cnt: got %0d, want 1", bus.issued_cnt); end
    bus.clr_stats = 1'b1;
    next_cycle();
    bus.clr_stats = 1'b0;
    bus.win_valid = 1'b0;
    tests_run += 3;
    if (bus.drop_cnt !== 16'h0) begin tests_failed++; $display("[TB] FAIL clear drop_cnt: got %h, want 0", bus.drop_cnt); end
    if (bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear overrun: got %b, want 0", bus.overrun); end
    if (bus.issued_cnt !== 16'h0) begin tests_failed++; $display("[TB] FAIL clear issued_cnt: got %h, want 0", bus.issued_cnt); end
    while (exp_cap.size() > 0) begin
      e = exp_cap.pop_front();
      g = -1; s = -1;
      if (cap_log.size() > 0) g = cap_log.pop_front();
      if (start_log.size() > 0) s = start_log.pop_front();
      tests_run += 2;
      if (g !== e) begin tests_failed++; $display("[TB] FAIL sat capture: got cycle %0d, want %0d", g, e); end
      if (s !== e + 1) begin tests_failed++; $display("[TB] FAIL sat eng_start: got cycle %0d, want %0d", s, e + 1); end
    end
    tests_run++;
    if (cap_log.size() + start_log.size() != 0) begin tests_failed++; $display("[TB] FAIL sat extra pulses: got %0d, want 0", cap_log.size() + start_log.size()); end
  endtask

  task automatic test_reset_mid();
    int e, g, s;
    apply_reset();
    bus.enable = 1'b1;
    bus.cfg_stride = 8'd1;
    next_cycle();
    bus.win_valid = 1'b1;
    exp_cap.push_back(cyc);
    next_cycle();
    bus.win_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bus.enable    = 1'b0;
    bus.win_valid = 1'b1;
    #1;
    tests_run += 4;
    if (bus.capture !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst capture: got %b, want 0", bus.capture); end
    if (bus.eng_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst eng_start: got %b, want 0", bus.eng_start); end
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst busy: got %b, want 0", bus.busy); end
    if (bus.issued_cnt !== 16'h0) begin tests_failed++; $display("[TB] FAIL midrst issued_cnt: got %h, want 0", bus.issued_cnt); end
    next_cycle();
    bus.win_valid = 1'b0;
    next_cycle();
    while (exp_cap.size() > 0) begin
      e = exp_cap.pop_front();
      g = -1; s = -1;
      if (cap_log.size() > 0) g = cap_log.pop_front();
      if (start_log.size() > 0) s = start_log.pop_front();
      tests_run += 2;
      if (g !== e) begin tests_failed++; $display("[TB] FAIL midrst capture cycle: got %0d, want %0d", g, e); end
      if (s !== e + 1) begin tests_failed++; $display("[TB] FAIL midrst eng_start cycle: got %0d, want %0d", s, e + 1); end
    end
    tests_run++;
    if (cap_log.size() + start_log.size() != 0) begin tests_failed++; $display("[TB] FAIL midrst extra pulses: got %0d, want 0", cap_log.size() + start_log.size()); end
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    test_reset();
    test_stride4();
    test_overrun();
    test_back_to_back();
    test_disable();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
